// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard: unified register address, latency and bypass records.
// GPRs and FPRs share one 64-entry space; bit FPR_SEL of the address selects the FPR half.
package issue_scoreboard_pkg;
   localparam int unsigned ADDR_W      = 6;
   localparam int unsigned FPR_SEL     = 5;
   localparam int unsigned NUM_REGS    = 64;
   localparam int unsigned MAX_LAT_DEF = 15;
   localparam int unsigned LAT_W_DEF   = $clog2(MAX_LAT_DEF + 1);
   localparam int unsigned XLEN_DEF    = 32;

   typedef logic [ADDR_W-1:0]    reg_addr_t;
   typedef logic [LAT_W_DEF-1:0] lat_t;

   typedef struct packed {
      logic                valid;
      reg_addr_t           addr;
      logic [XLEN_DEF-1:0] data;
   } bypass_vec_t;
endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard bundle: issue handshake, source/destination operands, bypass and writeback.
// The master side is decode plus backend; the slave side is the scoreboard.
interface issue_scoreboard_if #(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned NUM_BYP = 2,
   parameter int unsigned NUM_WB  = 1,
   parameter int unsigned MAX_LAT = 15,
   parameter int unsigned XLEN    = 32
);
   import issue_scoreboard_pkg::*;
   localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);

   logic                             issue_valid;
   logic                             issue_ready;
   logic                             issue_fire;
   logic      [NUM_SRC-1:0]          src_re;
   reg_addr_t [NUM_SRC-1:0]          src_addr;
   logic      [NUM_SRC-1:0][XLEN-1:0] src_rf_data;
   logic      [NUM_SRC-1:0][XLEN-1:0] src_data;
   logic                             dst_we;
   reg_addr_t                        dst_addr;
   logic      [LAT_W-1:0]            dst_lat;
   logic      [NUM_BYP-1:0]          byp_valid;
   reg_addr_t [NUM_BYP-1:0]          byp_addr;
   logic      [NUM_BYP-1:0][XLEN-1:0] byp_data;
   logic      [NUM_WB-1:0]           wb_valid;
   reg_addr_t [NUM_WB-1:0]           wb_addr;

   modport master (
      output issue_valid, src_re, src_addr, src_rf_data, dst_we, dst_addr, dst_lat,
      output byp_valid, byp_addr, byp_data, wb_valid, wb_addr,
      input  issue_ready, issue_fire, src_data
   );

   modport slave (
      input  issue_valid, src_re, src_addr, src_rf_data, dst_we, dst_addr, dst_lat,
      input  byp_valid, byp_addr, byp_data, wb_valid, wb_addr,
      output issue_ready, issue_fire, src_data
   );
endinterface

// File: rtl/issue_scoreboard_operand_resolver.sv
// Priority bypass mux for one source operand; the lowest-index bypass port wins.
// hit reports any bypass match so the scoreboard can accept a zero-countdown producer.
module operand_resolver
   import issue_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_BYP = 2,
   parameter int unsigned XLEN    = 32
) (
   input  logic                             re,
   input  reg_addr_t                        addr,
   input  logic      [XLEN-1:0]             rf_data,
   input  logic      [NUM_BYP-1:0]          byp_valid,
   input  reg_addr_t [NUM_BYP-1:0]          byp_addr,
   input  logic      [NUM_BYP-1:0][XLEN-1:0] byp_data,
   output logic      [XLEN-1:0]             data,
   output logic                             hit
);
   always_comb begin
      data = rf_data;
      hit  = 1'b0;
      // Walk from the oldest port down so the youngest match is written last.
      for (int i = int'(NUM_BYP) - 1; i >= 0; i--) begin
         if (byp_valid[i] && (byp_addr[i] == addr)) begin
            data = byp_data[i];
            hit  = 1'b1;
         end
      end
      if (!re || (addr == '0)) begin
         data = '0;
      end
   end
endmodule

// File: rtl/issue_scoreboard.sv
// Unified GPR/FPR issue scoreboard with latency countdown, bypass operand resolution,
// WAW ordering, flush and a saturating stall counter.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned NUM_BYP = 2,
   parameter int unsigned NUM_WB  = 1,
   parameter int unsigned MAX_LAT = 15,
   parameter int unsigned XLEN    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   issue_scoreboard_if.slave   bus,
   output logic [31:0]         perf_stall_cycles
);
   localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);

   logic [NUM_REGS-1:0]            busy_q, busy_d;
   logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
   logic [31:0]                    perf_q, perf_d;

   logic [NUM_SRC-1:0]           byp_hit;
   logic [NUM_SRC-1:0]           src_haz;
   logic [NUM_SRC-1:0][XLEN-1:0] src_data;
   logic [LAT_W-1:0]             lat_eff;
   logic                         waw_haz;
   logic                         ready;
   logic                         fire;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      operand_resolver #(
         .NUM_BYP (NUM_BYP),
         .XLEN    (XLEN)
      ) u_resolver (
         .re        (bus.src_re[s]),
         .addr      (bus.src_addr[s]),
         .rf_data   (bus.src_rf_data[s]),
         .byp_valid (bus.byp_valid),
         .byp_addr  (bus.byp_addr),
         .byp_data  (bus.byp_data),
         .data      (src_data[s]),
         .hit       (byp_hit[s])
      );
   end

   always_comb begin
      src_haz = '0;
      // A busy source is only safe once its producer has counted down and is on a bypass.
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         src_haz[s] = bus.src_re[s] & busy_q[bus.src_addr[s]] &
                      ((cnt_q[bus.src_addr[s]] != '0) | ~byp_hit[s]);
      end
      lat_eff = (bus.dst_lat == '0) ? LAT_W'(1) : bus.dst_lat;
      waw_haz = bus.dst_we & busy_q[bus.dst_addr] & (cnt_q[bus.dst_addr] > lat_eff);
   end

   assign ready           = ~(|src_haz | waw_haz);
   assign fire            = bus.issue_valid & ready & ~flush;
   assign bus.issue_ready = ready;
   assign bus.issue_fire  = fire;
   assign bus.src_data    = src_data;

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (busy_q[i] && (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - LAT_W'(1);
         end
      end
      for (int unsigned w = 0; w < NUM_WB; w++) begin
         if (bus.wb_valid[w]) begin
            busy_d[bus.wb_addr[w]] = 1'b0;
         end
      end
      // Issue overrides a same-cycle writeback; the issue cycle is the first latency cycle.
      if (fire && bus.dst_we && (bus.dst_addr != '0)) begin
         busy_d[bus.dst_addr] = 1'b1;
         cnt_d[bus.dst_addr]  = lat_eff - LAT_W'(1);
      end
      if (flush) begin
         busy_d = '0;
         cnt_d  = '0;
      end
   end

   always_comb begin
      perf_d = perf_q;
      if (bus.issue_valid && !ready && !flush && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
         perf_q <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         perf_q <= perf_d;
      end
   end

   assign perf_stall_cycles = perf_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazards, bypass priority, WAW, flush and async reset.
module tb_issue_scoreboard;
   import issue_scoreboard_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [31:0] perf;
   int          n_vec = 0;
   int          n_err = 0;
   int          stalls;

   issue_scoreboard_if bus ();

   issue_scoreboard u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .flush             (flush),
      .bus               (bus),
      .perf_stall_cycles (perf)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush           = 1'b0;
      bus.issue_valid = 1'b0;
      bus.src_re      = '0;
      bus.src_addr    = '0;
      bus.src_rf_data = '0;
      bus.dst_we      = 1'b0;
      bus.dst_addr    = '0;
      bus.dst_lat     = '0;
      bus.byp_valid   = '0;
      bus.byp_addr    = '0;
      bus.byp_data    = '0;
      bus.wb_valid    = '0;
      bus.wb_addr     = '0;
   endtask

   task automatic issue_dst(input logic [5:0] addr, input logic [3:0] lat);
      idle();
      bus.issue_valid = 1'b1;
      bus.dst_we      = 1'b1;
      bus.dst_addr    = addr;
      bus.dst_lat     = lat;
      #1;
      check_val("issue_fire_dst", {31'd0, bus.issue_fire}, 32'd1);
      step();
   endtask

   task automatic clear_reg(input logic [5:0] addr);
      idle();
      bus.wb_valid[0] = 1'b1;
      bus.wb_addr[0]  = addr;
      step();
      idle();
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      step();

      // Reset state, plain register-file read.
      bus.issue_valid    = 1'b1;
      bus.src_re         = 3'b001;
      bus.src_addr[0]    = 6'd5;
      bus.src_rf_data[0] = 32'h1234_5678;
      bus.src_addr[1]    = 6'd6;
      bus.src_rf_data[1] = 32'hFFFF_0000;
      #1;
      check_val("rst_ready", {31'd0, bus.issue_ready}, 32'd1);
      check_val("rst_src0_rf", bus.src_data[0], 32'h1234_5678);
      check_val("rst_src1_re0", bus.src_data[1], 32'h0);
      check_val("rst_perf", perf, 32'd0);
      step();

      // MUL to x3, latency 3; consumer stalls two cycles then takes the bypass.
      issue_dst(6'd3, 4'd3);
      idle();
      bus.issue_valid    = 1'b1;
      bus.src_re         = 3'b001;
      bus.src_addr[0]    = 6'd3;
      bus.src_rf_data[0] = 32'hAAAA_AAAA;
      #1;
      check_val("mul_stall1", {31'd0, bus.issue_ready}, 32'd0);
      step();
      check_val("mul_stall2", {31'd0, bus.issue_ready}, 32'd0);
      step();
      check_val("mul_nobyp", {31'd0, bus.issue_ready}, 32'd0);
      bus.byp_valid[0] = 1'b1;
      bus.byp_addr[0]  = 6'd3;
      bus.byp_data[0]  = 32'hDEAD_BEEF;
      #1;
      check_val("mul_ready", {31'd0, bus.issue_ready}, 32'd1);
      check_val("mul_byp_data", bus.src_data[0], 32'hDEAD_BEEF);
      check_val("mul_perf", perf, 32'd2);
      step();
      clear_reg(6'd3);

      // Bypass priority on f1 and x0 masking.
      bus.issue_valid    = 1'b1;
      bus.src_re         = 3'b011;
      bus.src_addr[0]    = 6'd33;
      bus.src_rf_data[0] = 32'h0000_0033;
      bus.src_addr[1]    = 6'd0;
      bus.src_rf_data[1] = 32'h0000_0055;
      bus.src_addr[2]    = 6'd33;
      bus.byp_valid      = 2'b11;
      bus.byp_addr[0]    = 6'd33;
      bus.byp_data[0]    = 32'h11;
      bus.byp_addr[1]    = 6'd33;
      bus.byp_data[1]    = 32'h22;
      #1;
      check_val("byp_prio", bus.src_data[0], 32'h11);
      check_val("byp_x0", bus.src_data[1], 32'h0);
      check_val("byp_re0", bus.src_data[2], 32'h0);
      bus.byp_addr[0] = 6'd0;
      bus.byp_data[0] = 32'h99;
      #1;
      check_val("byp_port1", bus.src_data[0], 32'h22);
      check_val("byp_x0_match", bus.src_data[1], 32'h0);
      check_val("byp_ready", {31'd0, bus.issue_ready}, 32'd1);
      step();
      idle();

      // WAW: DIV x7 lat 10 then ADD x7 lat 1 waits until the DIV count reaches 1.
      issue_dst(6'd7, 4'd10);
      bus.issue_valid = 1'b1;
      bus.dst_we      = 1'b1;
      bus.dst_addr    = 6'd7;
      bus.dst_lat     = 4'd1;
      #1;
      stalls = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.issue_ready) break;
         step();
         stalls++;
      end
      check_val("waw_stalls", stalls, 32'd8);
      check_val("waw_ready", {31'd0, bus.issue_ready}, 32'd1);
      check_val("waw_perf", perf, 32'd10);
      bus.wb_valid[0] = 1'b1;
      bus.wb_addr[0]  = 6'd7;
      #1;
      check_val("waw_fire", {31'd0, bus.issue_fire}, 32'd1);
      step();
      idle();
      bus.issue_valid = 1'b1;
      bus.src_re      = 3'b001;
      bus.src_addr[0] = 6'd7;
      #1;
      check_val("waw_wb_keeps_busy", {31'd0, bus.issue_ready}, 32'd0);
      clear_reg(6'd7);

      // Flush with four busy entries.
      issue_dst(6'd10, 4'd8);
      issue_dst(6'd11, 4'd8);
      issue_dst(6'd12, 4'd8);
      issue_dst(6'd13, 4'd8);
      idle();
      bus.issue_valid = 1'b1;
      bus.src_re      = 3'b111;
      bus.src_addr[0] = 6'd10;
      bus.src_addr[1] = 6'd11;
      bus.src_addr[2] = 6'd12;
      bus.dst_we      = 1'b1;
      bus.dst_addr    = 6'd13;
      bus.dst_lat     = 4'd1;
      #1;
      check_val("flush_pre_ready", {31'd0, bus.issue_ready}, 32'd0);
      flush = 1'b1;
      #1;
      check_val("flush_fire_blocked", {31'd0, bus.issue_fire}, 32'd0);
      step();
      flush = 1'b0;
      #1;
      check_val("flush_post_ready", {31'd0, bus.issue_ready}, 32'd1);
      check_val("flush_post_fire", {31'd0, bus.issue_fire}, 32'd1);
      check_val("flush_perf_hold", perf, 32'd10);
      step();
      idle();
      bus.issue_valid = 1'b1;
      flush           = 1'b1;
      #1;
      check_val("flush_ready_nofire_r", {31'd0, bus.issue_ready}, 32'd1);
      check_val("flush_ready_nofire", {31'd0, bus.issue_fire}, 32'd0);
      step();
      idle();

      // Async reset with x9 counting down from 5.
      issue_dst(6'd9, 4'd6);
      idle();
      bus.issue_valid    = 1'b1;
      bus.src_re         = 3'b001;
      bus.src_addr[0]    = 6'd9;
      bus.src_rf_data[0] = 32'h0000_0909;
      #1;
      check_val("arst_pre_ready", {31'd0, bus.issue_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check_val("arst_ready", {31'd0, bus.issue_ready}, 32'd1);
      check_val("arst_perf", perf, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check_val("arst_post_ready", {31'd0, bus.issue_ready}, 32'd1);
      check_val("arst_post_data", bus.src_data[0], 32'h0000_0909);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
